ctrl_branch_gshare: RTL

Parametrised next-generation fetch-stage branch predictor: a 2-bit saturating-counter BHT indexed by PC XOR speculative global history (gshare), plus a direct-mapped BTB with tag/target/valid. Sits beside the PC register in IF, returns the predicted next PC in the lookup cycle, and is trained from EX/commit with mispredict recovery of the global history. Adds a mispredict counter for performance monitoring.

---
 rtl/ctrl_branch_gshare.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ctrl_branch_gshare.sv
// Fetch-stage gshare branch predictor: 2-bit counter BHT plus direct-mapped BTB, with a mispredict counter.
// Define CTRL_BRANCH_GSHARE_EN to fold speculative global history into the BHT index; otherwise the BHT is PC-indexed.
module ctrl_branch_gshare #(
    parameter int BHT_IDX_W = 8,
    parameter int BTB_IDX_W = 6,
    parameter int GHR_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_i,
    input  logic             fetch_valid,
    output logic [31:0]      pc_o,
    output logic             predict_result,
    output logic [GHR_W-1:0] predict_ghr,
    input  logic             predict_update,
    input  logic [31:0]      branch_pc,
    input  logic [31:0]      branch_npc,
    input  logic             actual_result,
    input  logic [GHR_W-1:0] branch_ghr,
    input  logic             mispredict,
    output logic [31:0]      mispredict_cnt
);
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    logic [1:0]       bht        [BHT_N];
    logic [BTB_N-1:0] btb_valid;
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [31:0]      btb_target [BTB_N];
    logic [GHR_W-1:0] ghr;
    logic [31:0]      miss_cnt;

    logic [BHT_IDX_W-1:0] look_hist;
    logic [BHT_IDX_W-1:0] train_hist;
    logic [BHT_IDX_W-1:0] look_bht_idx;
    logic [BHT_IDX_W-1:0] train_bht_idx;
    logic [BTB_IDX_W-1:0] look_btb_idx;
    logic [BTB_IDX_W-1:0] train_btb_idx;
    logic [TAG_W-1:0]     look_tag;
    logic [TAG_W-1:0]     train_tag;
    logic                 hit;
    logic                 taken;
    logic                 btb_write;

    function automatic logic [1:0] sat_counter(input logic [1:0] cnt, input logic inc);
        if (inc)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    // Lookup: purely combinational so the prediction lands in the fetch cycle
    assign look_btb_idx = pc_i[BTB_IDX_W+1:2];
    assign look_tag     = pc_i[31:BTB_IDX_W+2];
    assign look_bht_idx = pc_i[BHT_IDX_W+1:2] ^ look_hist;
    assign hit          = btb_valid[look_btb_idx] && (btb_tag[look_btb_idx] == look_tag);
    assign taken        = hit && bht[look_bht_idx][1];

    assign pc_o           = rst ? 32'd0 : (taken ? btb_target[look_btb_idx] : pc_i + 32'd4);
    assign predict_result = !rst && taken;
    assign predict_ghr    = rst ? '0 : ghr;

    assign train_btb_idx = branch_pc[BTB_IDX_W+1:2];
    assign train_tag     = branch_pc[31:BTB_IDX_W+2];
    assign train_bht_idx = branch_pc[BHT_IDX_W+1:2] ^ train_hist;
    assign btb_write     = predict_update && actual_result && !rst;

`ifdef CTRL_BRANCH_GSHARE_EN
    assign look_hist  = BHT_IDX_W'(ghr);
    assign train_hist = BHT_IDX_W'(branch_ghr);

    // Recovery from a flushed mispredict wins over any speculative shift in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghr <= '0;
        else if (predict_update && mispredict)
            ghr <= {branch_ghr[GHR_W-2:0], actual_result};
        else if (fetch_valid && hit)
            ghr <= {ghr[GHR_W-2:0], taken};
    end

    logic unused_inputs;
    assign unused_inputs = ^branch_pc[1:0];
`else
    assign look_hist  = '0;
    assign train_hist = '0;
    assign ghr        = '0;

    logic unused_inputs;
    assign unused_inputs = ^{branch_pc[1:0], branch_ghr, fetch_valid};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++)
                bht[i] <= 2'b01;
        end else if (predict_update) begin
            bht[train_bht_idx] <= sat_counter(bht[train_bht_idx], actual_result);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            btb_valid <= '0;
        else if (btb_write)
            btb_valid[train_btb_idx] <= 1'b1;
    end

    // Tag/target payload is qualified by btb_valid, so it carries no reset
    always_ff @(posedge clk) begin
        if (btb_write) begin
            btb_tag[train_btb_idx]    <= train_tag;
            btb_target[train_btb_idx] <= branch_npc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            miss_cnt <= 32'd0;
        else if (predict_update && mispredict)
            miss_cnt <= miss_cnt + 32'd1;
    end

    assign mispredict_cnt = miss_cnt;

endmodule
